// File: rtl/ts_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ts_event_arbiter
//  Description : Timestamps the rising edge of each of four channel inputs,
//                holds one pending event per channel, and shares a single
//                downstream serializer among the channels with a round-robin
//                scheduler behind a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//     TS_WIDTH   width of the timestamp counter and of out_ts
//  Ports
//     clk        system clock, rising edge
//     rst        asynchronous active-high reset
//     ts         free-running timestamp, synchronous to clk
//     ch_in      synchronized channel inputs, bit i is channel i
//     out_valid  an output word is presented
//     out_ready  serializer accepts the presented word
//     out_chan   channel number of the presented event
//     out_ts     captured timestamp of the presented event
//     out_ovr    events on this channel were dropped before this word
//     pending    per-channel slot-full flags
//  Build option
//     TS_ARB_OVERRUN_EN  when defined, per-channel overrun flags are tracked
//                        and reported on out_ovr; otherwise out_ovr is 0 and
//                        dropped events vanish silently.
// ============================================================================
module ts_event_arbiter #(
   parameter int TS_WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [TS_WIDTH-1:0] ts,
   input  logic [3:0]          ch_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [1:0]          out_chan,
   output logic [TS_WIDTH-1:0] out_ts,
   output logic                out_ovr,
   output logic [3:0]          pending
);

   typedef enum logic [0:0] {
      S_IDLE    = 1'b0,
      S_PRESENT = 1'b1
   } state_t;

   localparam logic [1:0] c_LAST_RST = 2'd3;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_load;

   logic [3:0]          r_prev;
   logic [3:0]          w_event;
   logic [3:0]          r_full;
   logic [TS_WIDTH-1:0] r_slot_ts [4];
   logic [1:0]          r_last;
   logic [1:0]          w_grant;
   logic [1:0]          w_idx;
   logic                w_any_full;
   logic [3:0]          w_take;

   logic [1:0]          r_out_chan;
   logic [TS_WIDTH-1:0] r_out_ts;

   assign w_event    = ch_in & ~r_prev;
   assign w_any_full = |r_full;

   // Round-robin pick: the loop runs from the farthest candidate to the
   // nearest, so the last assignment wins and the first full slot after
   // r_last is granted. Offset 4 wraps to r_last itself.
   always_comb begin
      w_grant = r_last;
      w_idx   = 2'd0;
      for (int k = 4; k >= 1; k--) begin
         w_idx = r_last + 2'(k);
         if (r_full[w_idx]) begin
            w_grant = w_idx;
         end
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any_full) begin
               w_load      = 1'b1;
               w_state_nxt = S_PRESENT;
            end
         end
         S_PRESENT: begin
            if (out_ready) begin
               if (w_any_full) begin
                  w_load = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      w_take = 4'd0;
      for (int i = 0; i < 4; i++) begin
         w_take[i] = w_load && (w_grant == 2'(i));
      end
   end

   // ---------------------------------------------------------------- slots
   // A slot being handed to the output this cycle is free again, so an event
   // arriving in the same cycle refills it instead of being dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prev <= 4'd0;
         r_full <= 4'd0;
         for (int i = 0; i < 4; i++) begin
            r_slot_ts[i] <= '0;
         end
      end else begin
         r_prev <= ch_in;
         for (int i = 0; i < 4; i++) begin
            if (w_take[i]) begin
               r_full[i] <= w_event[i];
               if (w_event[i]) begin
                  r_slot_ts[i] <= ts;
               end
            end else if (w_event[i] && !r_full[i]) begin
               r_full[i]    <= 1'b1;
               r_slot_ts[i] <= ts;
            end
         end
      end
   end

`ifdef TS_ARB_OVERRUN_EN
   logic [3:0] r_ovr;
   logic       r_out_ovr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovr <= 4'd0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (w_take[i]) begin
               r_ovr[i] <= 1'b0;
            end else if (w_event[i] && r_full[i]) begin
               r_ovr[i] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_ovr <= 1'b0;
      end else if (w_load) begin
         r_out_ovr <= r_ovr[w_grant];
      end
   end

   assign out_ovr = r_out_ovr;
`else
   assign out_ovr = 1'b0;
`endif

   // ---------------------------------------------------------------- output
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last     <= c_LAST_RST;
         r_out_chan <= 2'd0;
         r_out_ts   <= '0;
      end else if (w_load) begin
         r_last     <= w_grant;
         r_out_chan <= w_grant;
         r_out_ts   <= r_slot_ts[w_grant];
      end
   end

   assign out_valid = (r_state == S_PRESENT);
   assign out_chan  = r_out_chan;
   assign out_ts    = r_out_ts;
   assign pending   = r_full;

endmodule
`default_nettype wire

// File: tb/tb_ts_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ts_event_arbiter
//  Description : Self-checking bench for ts_event_arbiter. Directed vectors,
//                hand-written corner sequences and random traffic, each cycle
//                compared against a slot/queue-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ts_event_arbiter;

   localparam int TW = 32;
`ifdef TS_ARB_OVERRUN_EN
   localparam bit OVR_EN = 1'b1;
`else
   localparam bit OVR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [TW-1:0] ts;
   logic [3:0]    ch_in;
   logic          out_valid;
   logic          out_ready;
   logic [1:0]    out_chan;
   logic [TW-1:0] out_ts;
   logic          out_ovr;
   logic [3:0]    pending;

   int n_checks;
   int n_errors;

   ts_event_arbiter #(.TS_WIDTH(TW)) dut (
      .clk       (clk),
      .rst       (rst),
      .ts        (ts),
      .ch_in     (ch_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_chan  (out_chan),
      .out_ts    (out_ts),
      .out_ovr   (out_ovr),
      .pending   (pending)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------ reference model
   bit            m_full [4];
   logic [TW-1:0] m_slot [4];
   bit            m_ovr  [4];
   logic [3:0]    m_prev;
   int            m_last;
   bit            m_valid;
   int            m_chan;
   logic [TW-1:0] m_ots;
   bit            m_oovr;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_full[i] = 0;
         m_slot[i] = '0;
         m_ovr[i]  = 0;
      end
      m_prev  = 4'd0;
      m_last  = 3;
      m_valid = 0;
      m_chan  = 0;
      m_ots   = '0;
      m_oovr  = 0;
   endtask

   // One clock edge: first the serializer side (word accepted / next word
   // picked from the pre-edge slot contents), then new events land in slots.
   task automatic model_edge(input logic [3:0] ch, input logic [TW-1:0] t,
                             input logic rdy);
      int g;
      g = -1;
      for (int k = 1; k <= 4; k++) begin
         int c;
         c = (m_last + k) % 4;
         if (g < 0 && m_full[c]) g = c;
      end
      if (g >= 0 && (!m_valid || rdy)) begin
         m_valid   = 1;
         m_chan    = g;
         m_ots     = m_slot[g];
         m_oovr    = OVR_EN ? m_ovr[g] : 1'b0;
         m_full[g] = 0;
         m_ovr[g]  = 0;
         m_last    = g;
      end else if (m_valid && rdy) begin
         m_valid = 0;
      end
      for (int i = 0; i < 4; i++) begin
         if (ch[i] && !m_prev[i]) begin
            if (!m_full[i]) begin
               m_full[i] = 1;
               m_slot[i] = t;
            end else if (OVR_EN) begin
               m_ovr[i] = 1;
            end
         end
      end
      m_prev = ch;
   endtask

   // ------------------------------------------------------ checking
   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model(input string tag);
      logic [3:0] mp;
      mp = {m_full[3], m_full[2], m_full[1], m_full[0]};
      check(tag, {24'd0, out_valid, out_chan, out_ts, out_ovr, pending},
            {24'd0, m_valid, 2'(m_chan), m_ots, m_oovr, mp});
   endtask

   task automatic step(input logic [3:0] ch, input logic [TW-1:0] t,
                       input logic rdy, input string tag);
      ch_in     = ch;
      ts        = t;
      out_ready = rdy;
      model_edge(ch, t, rdy);
      @(posedge clk);
      #1;
      compare_model(tag);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      ch_in     = 4'd0;
      out_ready = 1'b0;
      ts        = '0;
      model_reset();
      #1;
      check("reset_state", {24'd0, out_valid, out_chan, out_ts, out_ovr, pending}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // ------------------------------------------------------ vector table
   typedef struct {
      logic [3:0]    ch;
      logic [TW-1:0] t;
      logic          rdy;
      logic          ev;
      logic [1:0]    ec;
      logic [TW-1:0] ets;
      logic [3:0]    ep;
   } vec_t;

   vec_t tbl [9];

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b0; ch_in = 4'd0; ts = '0; out_ready = 1'b0;

      // Four simultaneous events at ts=0x20, five stalled cycles, then drain.
      tbl[0] = '{4'b1111, 32'h20, 1'b0, 1'b0, 2'd0, 32'h00, 4'b1111};
      tbl[1] = '{4'b0000, 32'h21, 1'b0, 1'b1, 2'd0, 32'h20, 4'b1110};
      tbl[2] = '{4'b0000, 32'h22, 1'b0, 1'b1, 2'd0, 32'h20, 4'b1110};
      tbl[3] = '{4'b0000, 32'h23, 1'b0, 1'b1, 2'd0, 32'h20, 4'b1110};
      tbl[4] = '{4'b0000, 32'h24, 1'b0, 1'b1, 2'd0, 32'h20, 4'b1110};
      tbl[5] = '{4'b0000, 32'h25, 1'b1, 1'b1, 2'd1, 32'h20, 4'b1100};
      tbl[6] = '{4'b0000, 32'h26, 1'b1, 1'b1, 2'd2, 32'h20, 4'b1000};
      tbl[7] = '{4'b0000, 32'h27, 1'b1, 1'b1, 2'd3, 32'h20, 4'b0000};
      tbl[8] = '{4'b0000, 32'h28, 1'b1, 1'b0, 2'd3, 32'h20, 4'b0000};

      // -------- single event
      do_reset();
      step(4'b0001, 32'h100, 1'b1, "single_m0");
      check("single_pend", {60'd0, pending}, 64'h1);
      check("single_nv", {63'd0, out_valid}, 64'd0);
      step(4'b0000, 32'h101, 1'b1, "single_m1");
      check("single_word", {28'd0, out_valid, out_chan, out_ts, out_ovr},
            {28'd0, 1'b1, 2'd0, 32'h100, 1'b0});
      step(4'b0000, 32'h102, 1'b1, "single_m2");
      check("single_end", {63'd0, out_valid}, 64'd0);

      // -------- table: simultaneous events with backpressure
      do_reset();
      for (int r = 0; r < 9; r++) begin
         step(tbl[r].ch, tbl[r].t, tbl[r].rdy, "tbl_model");
         check($sformatf("tbl_row%0d", r),
               {24'd0, out_valid, out_chan, out_ts, out_ovr, pending},
               {24'd0, tbl[r].ev, tbl[r].ec, tbl[r].ets, 1'b0, tbl[r].ep});
      end

      // -------- round-robin fairness
      do_reset();
      step(4'b0100, 32'h200, 1'b0, "rr_m0");
      step(4'b0000, 32'h201, 1'b0, "rr_m1");
      check("rr_grant2", {61'd0, out_valid, out_chan}, {61'd0, 1'b1, 2'd2});
      step(4'b1010, 32'h202, 1'b0, "rr_m2");
      step(4'b0000, 32'h203, 1'b1, "rr_m3");
      check("rr_first3", {29'd0, out_valid, out_chan, out_ts}, {29'd0, 1'b1, 2'd3, 32'h202});
      step(4'b0000, 32'h204, 1'b1, "rr_m4");
      check("rr_then1", {29'd0, out_valid, out_chan, out_ts}, {29'd0, 1'b1, 2'd1, 32'h202});
      step(4'b0000, 32'h205, 1'b1, "rr_m5");
      check("rr_idle", {63'd0, out_valid}, 64'd0);

      // -------- overrun: channel 0 occupies the output, channel 1 gets two edges
      do_reset();
      step(4'b0001, 32'h05, 1'b0, "ovr_m0");
      step(4'b0000, 32'h06, 1'b0, "ovr_m1");
      step(4'b0010, 32'h10, 1'b0, "ovr_m2");
      step(4'b0000, 32'h11, 1'b0, "ovr_m3");
      step(4'b0010, 32'h30, 1'b0, "ovr_m4");
      step(4'b0000, 32'h31, 1'b0, "ovr_m5");
      check("ovr_pend", {60'd0, pending}, 64'h2);
      step(4'b0000, 32'h32, 1'b1, "ovr_m6");
      check("ovr_word", {28'd0, out_valid, out_chan, out_ts, out_ovr},
            {28'd0, 1'b1, 2'd1, 32'h10, OVR_EN});
      check("ovr_pend1_clr", {63'd0, pending[1]}, 64'd0);
      step(4'b0000, 32'h33, 1'b1, "ovr_m7");
      check("ovr_idle", {63'd0, out_valid}, 64'd0);

      // -------- refill on load
      do_reset();
      step(4'b0001, 32'h3c, 1'b0, "refill_m0");
      step(4'b0000, 32'h3d, 1'b0, "refill_m1");
      step(4'b0100, 32'h40, 1'b0, "refill_m2");
      step(4'b0000, 32'h41, 1'b0, "refill_m3");
      step(4'b0100, 32'h50, 1'b1, "refill_m4");
      check("refill_first", {24'd0, out_valid, out_chan, out_ts, out_ovr, pending},
            {24'd0, 1'b1, 2'd2, 32'h40, 1'b0, 4'b0100});
      step(4'b0000, 32'h51, 1'b1, "refill_m5");
      check("refill_second", {29'd0, out_valid, out_chan, out_ts}, {29'd0, 1'b1, 2'd2, 32'h50});
      step(4'b0000, 32'h52, 1'b1, "refill_m6");
      check("refill_idle", {63'd0, out_valid}, 64'd0);

      // -------- asynchronous reset mid-word
      do_reset();
      step(4'b0100, 32'h60, 1'b0, "arst_m0");
      step(4'b0000, 32'h61, 1'b0, "arst_m1");
      step(4'b1000, 32'h62, 1'b0, "arst_m2");
      check("arst_before", {59'd0, out_valid, pending}, {59'd0, 1'b1, 4'b1000});
      #2;
      rst = 1'b1;
      #1;
      check("arst_async", {59'd0, out_valid, pending}, 64'd0);
      model_reset();
      ch_in = 4'd0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(4'b1001, 32'h70, 1'b0, "arst_m3");
      step(4'b0000, 32'h71, 1'b1, "arst_m4");
      check("arst_ch0_first", {29'd0, out_valid, out_chan, out_ts}, {29'd0, 1'b1, 2'd0, 32'h70});
      step(4'b0000, 32'h72, 1'b1, "arst_m5");
      check("arst_ch3_next", {29'd0, out_valid, out_chan, out_ts}, {29'd0, 1'b1, 2'd3, 32'h70});

      // -------- random traffic against the model
      do_reset();
      for (int n = 0; n < 600; n++) begin
         step(4'($urandom_range(0, 15)), TW'($urandom),
              ($urandom_range(0, 3) != 0), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ts_event_arbiter.md
# ts_event_arbiter

Captures the shared timestamp on the rising edge of each of the four channel inputs. Holds one pending event per channel. A round-robin scheduler shares the single downstream serializer among the channels through a valid/ready handshake. Sits in `root` between the channel input synchronizers and the serial output path, so simultaneous events on several channels are all delivered and none are lost silently.

## Interface
- `TS_WIDTH`, default 32: width of the timestamp counter and of `out_ts`.
- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `ts`  in  TS_WIDTH: free-running timestamp from the shared counter, synchronous to `clk`.
- `ch_in`  in  4: channel inputs, already synchronized to `clk` upstream; bit i is channel i.
- `out_valid`  out  1: an output word is presented.
- `out_ready`  in  1: the serializer accepts the word.
- `out_chan`  out  2: channel number of the presented event.
- `out_ts`  out  TS_WIDTH: captured timestamp.
- `out_ovr`  out  1: one or more events on this channel were dropped before this word (see Configuration).
- `pending`  out  4: per-channel slot-full flags.

## Operation
- **Edge detect:** `prev[i]` registers `ch_in[i]`.
  - An event on channel i is `ch_in[i] & ~prev[i]`, sampled at a clock edge.
  - On an event, `ts` as sampled at that same edge is stored.
- **Slots:** one slot per channel, holding `slot_ts[i]`, `full[i]` and `ovr[i]`. `pending = full`.
  - Event while the slot is empty: store `ts`, set `full[i]`.
  - Event while the slot is full and not being loaded this cycle: the new event is dropped, the stored (older) timestamp is kept, and `ovr[i]` is set.
  - Event in the same cycle the slot is loaded to the output: the slot is refilled with the new `ts`; no drop occurs.
- **Scheduler:** a two-state FSM, IDLE and PRESENT.
  - `last` is the round-robin pointer; its reset value is 3, so channel 0 has first priority.
  - Grant goes to the first full slot scanning `last+1`, `last+2`, … modulo 4.
  - IDLE:
    - If any slot is full: load the output registers from the granted slot, clear that slot's `full` and `ovr`, set `last` to the grant, and go to PRESENT.
    - Otherwise stay in IDLE.
  - PRESENT: `out_valid` is 1 and all outputs are held stable.
    - On `out_valid & out_ready` with another slot full: load the next grant in the same cycle and stay in PRESENT (back-to-back words).
    - On `out_valid & out_ready` with no slot full: go to IDLE and drop `out_valid`.
    - `out_ready` while IDLE is ignored.
- **Arithmetic:** none. `ts` wrap-around is passed through unchanged; the downstream logic handles it.

## Timing
- **Reset values:**
  - `out_valid` = 0, `out_chan` = 0, `out_ts` = 0, `out_ovr` = 0, `pending` = 0.
  - Also cleared: `prev` = 0, all slots empty, `last` = 3, FSM in IDLE.
- **Reset mid-operation:** all state clears immediately and asynchronously. A presented word is abandoned and not re-sent.
- **Latency:**
  - A rising edge of `ch_in[i]` sampled at edge k sets `full[i]` after edge k.
  - With the FSM idle, `out_valid` = 1 after edge k+1.
- **Throughput:** one word per cycle while `out_ready` is held high and slots remain pending.
- A `ch_in` level held high produces exactly one event. A new event requires a low cycle first.
- **Four simultaneous events:** delivered in round-robin order starting from `last+1`.

## Configuration
- Macro: `TS_ARB_OVERRUN_EN`.
- **Defined:** `ovr[i]` tracking is implemented as described; `out_ovr` reports drops on the delivered word's channel.
- **Undefined:** no `ovr` registers exist, `out_ovr` is tied to 0, and dropped events are discarded silently. All other behaviour is identical.

## Test plan
- **Single event:** after reset, with `ts` = 0x100 at the sampled edge, pulse `ch_in[0]` for 1 cycle while `out_ready` = 1.
  - Required: `out_valid` for exactly 1 cycle, 2 edges later, with `out_chan` = 0, `out_ts` = 0x100, `out_ovr` = 0.
- **Simultaneous events with backpressure:** set `ch_in` = 4'b1111 in one cycle with `ts` = 0x20, holding `out_ready` = 0 for 5 cycles and then 1.
  - Required: words for channels 0, 1, 2, 3 in that order, all with `out_ts` = 0x20, on 4 consecutive cycles.
  - Required: outputs stay stable throughout the stall.
- **Round-robin fairness:** grant channel 2; then events on channels 1 and 3 arrive in the same cycle.
  - Required: channel 3 is delivered before channel 1.
- **Overrun, macro defined:** with `out_ready` = 0, give channel 1 two edges at `ts` = 0x10 and 0x30, then release `out_ready`.
  - Required: one word with `out_ts` = 0x10 and `out_ovr` = 1, and `pending[1]` = 0 afterwards.
  - Required with the macro undefined: the same word but with `out_ovr` = 0.
- **Refill on load:** an edge on channel 2 occurs in the same cycle its slot is loaded.
  - Required: a second word for channel 2 carrying the new `ts`.
- **Reset mid-word:** assert `rst` while `out_valid` = 1 and `out_ready` = 0.
  - Required: `out_valid` and `pending` go to 0 without waiting for a clock edge.
  - Required: after release, the next event is granted starting from channel 0.
